// File: rtl/muldiv_ctrl.sv
// HI/LO sequencer for the EX stage: fixed-latency multiply, 32-step restoring divide, MTHI/MTLO.
// Optional macro MULDIV_EARLY_OUT_EN: divides with |b| > |a| retire without iterating.
module muldiv_ctrl #(
  parameter int MUL_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_e,
  input  logic        flush_e,
  input  logic [7:0]  alucontrol_e,
  input  logic [31:0] src_a_e,
  input  logic [31:0] src_b_e,
  output logic        stall_md,
  output logic        busy,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam logic [7:0] ALU_MULT  = 8'h18;
  localparam logic [7:0] ALU_MULTU = 8'h19;
  localparam logic [7:0] ALU_DIV   = 8'h1A;
  localparam logic [7:0] ALU_DIVU  = 8'h1B;
  localparam logic [7:0] ALU_MTHI  = 8'h11;
  localparam logic [7:0] ALU_MTLO  = 8'h13;
  localparam int CNT_W = ($clog2(MUL_CYCLES) > 5) ? $clog2(MUL_CYCLES) : 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_rem;
  logic [31:0]      r_q;
  logic [31:0]      r_b;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_busy;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;

  logic        w_is_mul;
  logic        w_is_div;
  logic        w_signed;
  logic        w_neg_a;
  logic        w_neg_b;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic        w_start;
  logic        w_early;
  logic        w_stall;
  logic [32:0] w_rem_sh;
  logic        w_ge;
  logic [31:0] w_rem_nxt;
  logic [31:0] w_q_nxt;
  logic [31:0] w_quot_fin;
  logic [31:0] w_rem_fin;
  logic [63:0] w_prod_mag;
  logic [63:0] w_prod;

  assign w_is_mul = (alucontrol_e == ALU_MULT) || (alucontrol_e == ALU_MULTU);
  assign w_is_div = (alucontrol_e == ALU_DIV) || (alucontrol_e == ALU_DIVU);
  assign w_signed = (alucontrol_e == ALU_MULT) || (alucontrol_e == ALU_DIV);
  assign w_neg_a  = w_signed & src_a_e[31];
  assign w_neg_b  = w_signed & src_b_e[31];
  assign w_abs_a  = w_neg_a ? (32'd0 - src_a_e) : src_a_e;
  assign w_abs_b  = w_neg_b ? (32'd0 - src_b_e) : src_b_e;
  assign w_start  = valid_e & ~flush_e & (r_state == S_IDLE) & (w_is_mul | w_is_div);

`ifdef MULDIV_EARLY_OUT_EN
  assign w_early = (src_b_e != 32'd0) && (w_abs_b > w_abs_a);
`else
  assign w_early = 1'b0;
`endif

  // One restoring step on magnitudes; the remainder stays below |b| so bit 32 is only needed for the compare
  assign w_rem_sh   = {r_rem, r_q[31]};
  assign w_ge       = (w_rem_sh >= {1'b0, r_b});
  assign w_rem_nxt  = w_ge ? 32'(w_rem_sh - {1'b0, r_b}) : w_rem_sh[31:0];
  assign w_q_nxt    = {r_q[30:0], w_ge};
  assign w_quot_fin = r_neg_q ? (32'd0 - w_q_nxt) : w_q_nxt;
  assign w_rem_fin  = r_neg_r ? (32'd0 - w_rem_nxt) : w_rem_nxt;
  assign w_prod_mag = {32'd0, r_q} * {32'd0, r_b};
  assign w_prod     = r_neg_q ? (64'd0 - w_prod_mag) : w_prod_mag;

  // Pipeline hold: start cycle and every non-flushed MUL/DIV cycle
  always_comb begin
    w_stall = 1'b0;
    case (r_state)
      S_IDLE:       w_stall = w_start;
      S_MUL, S_DIV: w_stall = ~flush_e;
      default:      w_stall = 1'b0;
    endcase
  end

  assign stall_md = w_stall & ~rst;
  assign busy     = r_busy;
  assign hi_o     = r_hi;
  assign lo_o     = r_lo;

  // Sequencer FSM, operand latches and HI/LO ownership
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rem   <= 32'd0;
      r_q     <= 32'd0;
      r_b     <= 32'd0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_busy  <= 1'b0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_rem   <= 32'd0;
            r_q     <= w_abs_a;
            r_b     <= w_abs_b;
            r_neg_q <= w_neg_a ^ w_neg_b;
            r_neg_r <= w_neg_a;
            if (w_is_mul) begin
              r_state <= S_MUL;
              r_cnt   <= CNT_W'(MUL_CYCLES - 1);
              r_busy  <= 1'b1;
            end else if (src_b_e == 32'd0) begin
              r_state <= S_DONE;
              r_hi    <= src_a_e;
              r_lo    <= 32'hFFFF_FFFF;
            end else if (w_early) begin
              r_state <= S_DONE;
              r_hi    <= src_a_e;
              r_lo    <= 32'd0;
            end else begin
              r_state <= S_DIV;
              r_cnt   <= CNT_W'(5'd31);
              r_busy  <= 1'b1;
            end
          end else if (valid_e && !flush_e && (alucontrol_e == ALU_MTHI)) begin
            r_hi <= src_a_e;
          end else if (valid_e && !flush_e && (alucontrol_e == ALU_MTLO)) begin
            r_lo <= src_a_e;
          end
        end
        S_MUL: begin
          if (flush_e) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (r_cnt == '0) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_hi    <= w_prod[63:32];
            r_lo    <= w_prod[31:0];
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_DIV: begin
          if (flush_e) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_rem <= w_rem_nxt;
            r_q   <= w_q_nxt;
            if (r_cnt == '0) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_hi    <= w_rem_fin;
              r_lo    <= w_quot_fin;
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
